// File: rtl/seven_segment_reader.sv
// seven_segment_reader
//
// Recovers the four BCD digits shown on a multiplexed common-anode style
// seven-segment display by watching the segment and digit-select lines. A
// pattern must stay unchanged for STABLE_CYCLES consecutive clocks before it
// is accepted into its digit slot. Once all four slots have been captured
// since the last frame, they are offered as one frame on a valid/ready port.
//
// Parameters
//   STABLE_CYCLES : dwell length (in clocks) needed to accept a digit, 2..255
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   seg_in     : segment lines, active high, bit 6 = a ... bit 0 = g
//   an_in      : digit select, active high, expected one-hot (bit i = slot i)
//   out_ready  : consumer accepts the presented frame
//   out_valid  : frame_data/frame_err hold a complete frame
//   frame_data : BCD digits, slot i at bits [4i+3:4i]
//   frame_err  : bit i set when slot i held an unrecognised pattern
//   overrun    : sticky, a frame completed while the previous one was pending

module seven_segment_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] frame_data,
   output logic [3:0]  frame_err,
   output logic        overrun
);

   localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

   logic [3:0]  h_an;
   logic [6:0]  h_seg;
   logic [7:0]  dwell_cnt;
   logic        done;
   logic [15:0] slot_data;
   logic [3:0]  slot_err;
   logic [3:0]  seen;

   logic [3:0]  dec_val;
   logic        dec_err;
   logic        input_match;
   logic        an_onehot;
   logic        slot_write;
   logic        frame_done;

   // Translate the held segment pattern back into a BCD digit. Anything that
   // is not one of the ten digit shapes reads as F and raises the error bit,
   // so a half-lit or ghosted digit never masquerades as a valid value.
   always_comb begin
      dec_val = 4'hF;
      dec_err = 1'b1;
      case (h_seg)
         7'b1111110: begin dec_val = 4'd0; dec_err = 1'b0; end
         7'b0110000: begin dec_val = 4'd1; dec_err = 1'b0; end
         7'b1101101: begin dec_val = 4'd2; dec_err = 1'b0; end
         7'b1111001: begin dec_val = 4'd3; dec_err = 1'b0; end
         7'b0110011: begin dec_val = 4'd4; dec_err = 1'b0; end
         7'b1011011: begin dec_val = 4'd5; dec_err = 1'b0; end
         7'b1011111: begin dec_val = 4'd6; dec_err = 1'b0; end
         7'b1110000: begin dec_val = 4'd7; dec_err = 1'b0; end
         7'b1111111: begin dec_val = 4'd8; dec_err = 1'b0; end
         7'b1111011: begin dec_val = 4'd9; dec_err = 1'b0; end
         default:    begin dec_val = 4'hF; dec_err = 1'b1; end
      endcase
   end

   // A slot is written once per dwell: the moment the counter reaches its
   // terminal value, provided this dwell has not already written and the held
   // select names exactly one digit. Blank or overlapping selects (0000, or
   // several bits during a scan transition) are ignored entirely. A frame is
   // ready to go out once every slot has been seen since the last frame.
   always_comb begin
      input_match = ({an_in, seg_in} == {h_an, h_seg});
      an_onehot   = (h_an != 4'b0000) && ((h_an & (h_an - 4'd1)) == 4'b0000);
      slot_write  = (dwell_cnt == LAST_COUNT) && !done && an_onehot;
      frame_done  = (seen == 4'b1111);
   end

   // Hold register and dwell counter. Any change on the display lines restarts
   // the dwell from scratch; an unchanged display lets the counter climb and
   // park at its terminal value, while the done flag stops a long dwell from
   // writing its slot again on every later cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_an      <= 4'b0000;
         h_seg     <= 7'b0000000;
         dwell_cnt <= 8'd0;
         done      <= 1'b0;
      end else if (!input_match) begin
         h_an      <= an_in;
         h_seg     <= seg_in;
         dwell_cnt <= 8'd0;
         done      <= 1'b0;
      end else begin
         if (dwell_cnt != LAST_COUNT) begin
            dwell_cnt <= dwell_cnt + 8'd1;
         end
         if (slot_write) begin
            done <= 1'b1;
         end
      end
   end

   // Slot storage and per-slot seen tracking. A slot revisited before the frame
   // goes out simply takes the newer value. When a frame completes the seen
   // mask restarts, but a slot written on that very edge still counts toward
   // the next frame so no capture is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_data <= 16'h0000;
         slot_err  <= 4'b0000;
         seen      <= 4'b0000;
      end else begin
         seen <= (frame_done ? 4'b0000 : seen) | (slot_write ? h_an : 4'b0000);
         if (slot_write) begin
            for (int i = 0; i < 4; i++) begin
               if (h_an[i]) begin
                  slot_data[4*i +: 4] <= dec_val;
                  slot_err[i]         <= dec_err;
               end
            end
         end
      end
   end

   // Output frame register and handshake. A completed frame is taken if the
   // output is empty or is being emptied on this same edge; otherwise the new
   // frame is thrown away and the sticky overrun flag records the loss so the
   // consumer can tell it fell behind. overrun only clears on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         frame_data <= 16'h0000;
         frame_err  <= 4'b0000;
         overrun    <= 1'b0;
      end else if (frame_done) begin
         if (!out_valid || out_ready) begin
            frame_data <= slot_data;
            frame_err  <= slot_err;
            out_valid  <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
